// File: rtl/match_event_capture.sv
// Timestamps qualifying correlation hits against a strobe-driven sample counter,
// applies re-trigger holdoff and queues {ts, seq} events in a small FWFT FIFO.
module match_event_capture #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxstrobe,
   input  logic        valid,
   input  logic        match,
   input  logic        enable,
   input  logic        clear,
   input  logic [7:0]  holdoff,
   input  logic        ev_rd,
   output logic        ev_valid,
   output logic [31:0] ev_ts,
   output logic [7:0]  ev_seq,
   output logic [15:0] match_count,
   output logic        overrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   typedef enum logic {IDLE, HOLD} state_t;

   typedef struct packed {
      logic [31:0] ts;
      logic [7:0]  seq;
   } entry_t;

   state_t        state_q, state_d;
   logic [31:0]   ts_q, ts_d;
   logic [7:0]    hc_q, hc_d;
   logic [7:0]    seq_q, seq_d;
   logic [15:0]   match_count_q, match_count_d;
   logic          overrun_q, overrun_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ev_valid_q, ev_valid_d;
   logic [31:0]   ev_ts_q, ev_ts_d;
   logic [7:0]    ev_seq_q, ev_seq_d;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];

   logic   qual, accept, push, pop, full, empty;
   entry_t head;

   // NOTE: every signal written here gets a default first and uses blocking '=',
   // so no path through the block leaves a value unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      ts_d          = ts_q;
      hc_d          = hc_q;
      seq_d         = seq_q;
      match_count_d = match_count_q;
      overrun_d     = overrun_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      mem_d         = mem_q;
      accept        = 1'b0;

      qual  = enable & valid & match;
      full  = (cnt_q == CW'(DEPTH));
      empty = (cnt_q == '0);

      case (state_q)
         IDLE: begin
            if (qual) begin
               accept = 1'b1;
               if (holdoff != 8'd0) begin
                  hc_d    = holdoff;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Hits here are discarded; only enabled strobes run the holdoff down.
            if (enable && rxstrobe) begin
               hc_d = hc_q - 8'd1;
               if (hc_q == 8'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (enable && rxstrobe) ts_d = ts_q + 32'd1;

      pop  = ev_rd & ~empty;
      push = accept & (~full | pop);

      if (accept && match_count_q != 16'hFFFF) match_count_d = match_count_q + 16'd1;
      if (accept && !push) overrun_d = 1'b1;

      if (push) begin
         mem_d[wr_ptr_q] = '{ts: ts_q, seq: seq_q};
         wr_ptr_d        = wr_ptr_q + PW'(1);
         seq_d           = seq_q + 8'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      // Head is registered from the post-update FIFO so outputs carry no input paths.
      head       = mem_d[rd_ptr_d];
      ev_valid_d = (cnt_d != '0);
      ev_ts_d    = ev_valid_d ? head.ts  : 32'd0;
      ev_seq_d   = ev_valid_d ? head.seq : 8'd0;

      if (clear) begin
         state_d       = IDLE;
         ts_d          = '0;
         hc_d          = '0;
         seq_d         = '0;
         match_count_d = '0;
         overrun_d     = 1'b0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         cnt_d         = '0;
         ev_valid_d    = 1'b0;
         ev_ts_d       = '0;
         ev_seq_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         ts_q          <= '0;
         hc_q          <= '0;
         seq_q         <= '0;
         match_count_q <= '0;
         overrun_q     <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         ev_valid_q    <= 1'b0;
         ev_ts_q       <= '0;
         ev_seq_q      <= '0;
      end else begin
         state_q       <= state_d;
         ts_q          <= ts_d;
         hc_q          <= hc_d;
         seq_q         <= seq_d;
         match_count_q <= match_count_d;
         overrun_q     <= overrun_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         ev_valid_q    <= ev_valid_d;
         ev_ts_q       <= ev_ts_d;
         ev_seq_q      <= ev_seq_d;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and count define which
   // entries are live, and the visible head registers are reset separately.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign ev_valid    = ev_valid_q;
   assign ev_ts       = ev_ts_q;
   assign ev_seq      = ev_seq_q;
   assign match_count = match_count_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_match_event_capture.sv
// Scoreboard bench for match_event_capture: expected events are queued as hits
// are driven and compared against the FIFO head as it is drained.
module tb_match_event_capture;

   localparam int DEPTH_LOG2 = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rxstrobe = 1'b0;
   logic        valid = 1'b0;
   logic        match = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  holdoff = 8'd0;
   logic        ev_rd = 1'b0;
   logic        ev_valid;
   logic [31:0] ev_ts;
   logic [7:0]  ev_seq;
   logic [15:0] match_count;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] ts;
      logic [7:0]  seq;
   } ev_t;

   ev_t sb[$];

   match_event_capture #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk         (clk),
      .reset       (reset),
      .rxstrobe    (rxstrobe),
      .valid       (valid),
      .match       (match),
      .enable      (enable),
      .clear       (clear),
      .holdoff     (holdoff),
      .ev_rd       (ev_rd),
      .ev_valid    (ev_valid),
      .ev_ts       (ev_ts),
      .ev_seq      (ev_seq),
      .match_count (match_count),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive at the falling edge, let the rising edge act, return at the next falling edge.
   task automatic cyc(input logic s, input logic h, input logic r);
      rxstrobe = s;
      valid    = h;
      match    = h;
      ev_rd    = r;
      @(posedge clk);
      @(negedge clk);
      rxstrobe = 1'b0;
      valid    = 1'b0;
      match    = 1'b0;
      ev_rd    = 1'b0;
   endtask

   task automatic hit_exp(input logic [31:0] ts, input logic [7:0] seq);
      sb.push_back('{ts: ts, seq: seq});
      cyc(1'b0, 1'b1, 1'b0);
   endtask

   task automatic strobes(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         repeat (gap) cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic pop_one(input string tag);
      ev_t e;
      e = sb.pop_front();
      check({tag, "_valid"}, ev_valid, 1'b1);
      if (ev_valid) begin
         check({tag, "_ts"}, ev_ts, e.ts);
         check({tag, "_seq"}, ev_seq, e.seq);
      end
      cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic drain(input string tag);
      while (sb.size() > 0) pop_one(tag);
      check({tag, "_empty"}, ev_valid, 1'b0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      sb.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ev_valid"}, ev_valid, 1'b0);
      check({tag, "_ev_ts"}, ev_ts, 32'd0);
      check({tag, "_ev_seq"}, ev_seq, 8'd0);
      check({tag, "_count"}, match_count, 16'd0);
      check({tag, "_overrun"}, overrun, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Basic hit after the 5th strobe.
      enable  = 1'b1;
      holdoff = 8'd0;
      strobes(5, 15);
      hit_exp(32'd5, 8'd0);
      check("basic_valid", ev_valid, 1'b1);
      check("basic_count", match_count, 16'd1);
      drain("basic");

      // Holdoff 3, hit every cycle, strobe every 16: accepts at ts 0 and 4.
      do_clear();
      holdoff = 8'd3;
      sb.push_back('{ts: 32'd0, seq: 8'd0});
      sb.push_back('{ts: 32'd4, seq: 8'd1});
      for (int i = 0; i < 80; i++) cyc(i % 16 == 0, 1'b1, 1'b0);
      check("hold_count", match_count, 16'd2);
      drain("hold");

      // Overrun: six hits into a four-deep FIFO.
      do_clear();
      holdoff = 8'd0;
      for (int i = 0; i < 4; i++) hit_exp(32'd0, 8'(i));
      check("ovr_before", overrun, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("ovr_flag", overrun, 1'b1);
      check("ovr_count", match_count, 16'd6);
      drain("ovr");
      check("ovr_sticky", overrun, 1'b1);

      // Full FIFO with push and pop in the same cycle.
      do_clear();
      for (int i = 0; i < 4; i++) hit_exp(32'd0, 8'(i));
      begin
         ev_t e;
         e = sb.pop_front();
         check("pp_head_ts", ev_ts, e.ts);
         check("pp_head_seq", ev_seq, e.seq);
      end
      sb.push_back('{ts: 32'd0, seq: 8'd4});
      cyc(1'b0, 1'b1, 1'b1);
      check("pp_overrun", overrun, 1'b0);
      check("pp_count", match_count, 16'd5);
      drain("pp");

      // Timestamp wrap, then hit-count saturation.
      do_clear();
      force dut.ts_q = 32'hFFFF_FFFF;
      cyc(1'b0, 1'b0, 1'b0);
      release dut.ts_q;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      hit_exp(32'd0, 8'd0);
      drain("wrap");
      for (int i = 0; i < 70000; i++) cyc(1'b0, 1'b1, 1'b1);
      check("sat_count", match_count, 16'hFFFF);
      check("sat_overrun", overrun, 1'b0);

      // Async reset mid-holdoff.
      do_clear();
      holdoff = 8'd200;
      hit_exp(32'd0, 8'd0);
      check("rst_pre_valid", ev_valid, 1'b1);
      #2 reset = 1'b0;
      #1 check_zero("rst_async");
      sb.delete();
      #1 reset = 1'b1;
      @(negedge clk);
      hit_exp(32'd0, 8'd0);
      check("rst_post_count", match_count, 16'd1);
      drain("rst_post");

      // Synchronous clear mid-holdoff.
      do_clear();
      hit_exp(32'd0, 8'd0);
      check("clr_pre_count", match_count, 16'd1);
      do_clear();
      check_zero("clr");
      hit_exp(32'd0, 8'd0);
      check("clr_post_count", match_count, 16'd1);
      drain("clr_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
